i2s_slave_xcvr: RTL



---
 rtl/i2s_slave_xcvr.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/i2s_slave_xcvr.sv
// rtl/i2s_slave_xcvr.sv - I2S target transceiver; SCLK/LRCK/SDATA oversampled on clk
module i2s_slave_xcvr #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_in,
    input  logic              lrck_in,
    input  logic              sdata_in,
    output logic              sdata_out,
    input  logic [DATA_W-1:0] tx_l,
    input  logic [DATA_W-1:0] tx_r,
    output logic              tx_rd,
    output logic [DATA_W-1:0] rx_l,
    output logic [DATA_W-1:0] rx_r,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam logic [5:0] DW6     = 6'(DATA_W);
    localparam logic [5:0] LAST6   = 6'(DATA_W - 1);
    localparam logic [5:0] CNT_MAX = 6'd63;

    logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, sdata_sync_q;
    logic                   sclk_prev_q;
    logic                   lrck_prev_q;
    logic                   lrck_seen_q;
    logic                   chan_q;
    logic [5:0]             cnt_q;
    logic                   locked_q;
    logic                   have_left_q;
    logic [DATA_W-2:0]      rx_shift_q;
    logic [DATA_W-1:0]      rx_hold_q, rx_l_q, rx_r_q;
    logic                   rx_valid_q, frame_err_q, tx_rd_q, sdata_out_q;
    logic [DATA_W-1:0]      tx_sh_l_q, tx_sh_r_q;

    logic              sclk_s, lrck_s, sdata_s;
    logic              rise, fall, lr_change, bit_slot, word_done, tx_bit;
    logic [5:0]        cnt_inc;
    logic [DATA_W-1:0] rx_word, tx_word;

    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        lrck_s    = lrck_sync_q[SYNC_STAGES-1];
        sdata_s   = sdata_sync_q[SYNC_STAGES-1];
        rise      = sclk_s & ~sclk_prev_q;
        fall      = ~sclk_s & sclk_prev_q;
        // No LRCK change can be claimed until one rise has recorded a reference level
        lr_change = lrck_seen_q & (lrck_s != lrck_prev_q);
        bit_slot  = locked_q & ~lr_change & (cnt_q < DW6);
        word_done = bit_slot & (cnt_q == LAST6);
        cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 6'd1;
        rx_word   = {rx_shift_q, sdata_s};
        tx_word   = chan_q ? tx_sh_r_q : tx_sh_l_q;
        tx_bit    = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == 6'(DATA_W - 1 - i)) tx_bit = tx_word[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            lrck_prev_q  <= 1'b0;
            lrck_seen_q  <= 1'b0;
            chan_q       <= 1'b0;
            cnt_q        <= CNT_MAX;
            locked_q     <= 1'b0;
            have_left_q  <= 1'b0;
            rx_shift_q   <= '0;
            rx_hold_q    <= '0;
            rx_l_q       <= '0;
            rx_r_q       <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_rd_q      <= 1'b0;
            tx_sh_l_q    <= '0;
            tx_sh_r_q    <= '0;
            sdata_out_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_in};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata_in};
            sclk_prev_q  <= sclk_s;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_rd_q      <= 1'b0;

            // Shadows load while tx_rd is high, so tx_l/tx_r seen during the pulse are used
            if (tx_rd_q) begin
                tx_sh_l_q <= tx_l;
                tx_sh_r_q <= tx_r;
            end

            if (rise) begin
                lrck_prev_q <= lrck_s;
                lrck_seen_q <= 1'b1;
                if (lr_change) begin
                    cnt_q    <= 6'd0;
                    chan_q   <= lrck_s;
                    locked_q <= 1'b1;
                    if (locked_q && (cnt_q < DW6)) begin
                        frame_err_q <= 1'b1;
                        have_left_q <= 1'b0;
                    end
                    if (!lrck_s) tx_rd_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                end

                if (bit_slot) begin
                    rx_shift_q <= rx_word[DATA_W-2:0];
                    if (word_done) begin
                        if (!chan_q) begin
                            rx_hold_q   <= rx_word;
                            have_left_q <= 1'b1;
                        end else if (have_left_q) begin
                            rx_l_q      <= rx_hold_q;
                            rx_r_q      <= rx_word;
                            rx_valid_q  <= 1'b1;
                            have_left_q <= 1'b0;
                        end
                    end
                end
            end

            if (fall) begin
                sdata_out_q <= (locked_q && (cnt_q < DW6)) ? tx_bit : 1'b0;
            end
        end
    end

    assign sdata_out = sdata_out_q;
    assign tx_rd     = tx_rd_q;
    assign rx_l      = rx_l_q;
    assign rx_r      = rx_r_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule
